encode4_2_seq: RTL
==================

Name: encode4_2_seq

Overview:
- Sequential 4-to-2 encoder; the inverse of the 2-to-4 decoder path.
- Accepts a 4-bit request vector through a valid/ready handshake and latches it.
- Emits the 2-bit index of every set bit, one index per handshake, lowest index first, with a last flag.
- Feeds downstream logic that drives the decoder with one code at a time.

Parameters:
- N, 4, input vector width; must be a power of two, at least 2.
- W, 2, code width; must equal log2(N). Checked by an elaboration-time guard.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  request vector I is valid
- in_ready  output  1  block can accept a vector
- I  input  N  request vector; bit k set means code k is to be emitted
- y  output  W  encoded index
- y_valid  output  1  y is valid
- y_ready  input  1  consumer accepts y
- y_last  output  1  current y is the final code of this vector
- zero  output  1  one-cycle pulse: an all-zero vector was accepted

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, pend=0, zero=0.
  - Resulting outputs: y=0, y_valid=0, y_last=0, in_ready=1.
  - rst overrides every other input on the same edge, including mid-scan; pending codes are discarded.
- Output timing:
  - All outputs are functions of registered state only; there is no combinational path from inputs to outputs.
  - in_ready = (state==IDLE).
- IDLE, when in_valid & in_ready at an edge:
  - I != 0: pend <= I, state <= SCAN.
  - I == 0: zero <= 1 for exactly one cycle; state stays IDLE.
- IDLE, no handshake: zero <= 0 and pend is held.
- SCAN:
  - y_valid=1.
  - y = index of the lowest set bit of pend.
  - y_last=1 iff pend has exactly one bit set.
- On y_valid & y_ready at an edge:
  - Clear the lowest set bit of pend.
  - If y_last, state <= IDLE.
- Backpressure: while y_ready=0, y, y_valid, y_last and pend hold stable.
- in_valid during SCAN is ignored (in_ready=0) and I is not sampled; the upstream must hold its vector.
- Latency: vector accepted at edge k; first code valid in the cycle after edge k; codes can be taken one per cycle.
- Turnaround: after the last code is accepted there is one IDLE cycle (in_ready=1) before a new vector can be latched. A new vector accepted at that edge produces a code the following cycle. This gives a minimum of 1 bubble between vectors.
- A full vector of N ones emits codes 0..N-1 in N consecutive cycles if y_ready is held high.
- pend is never 0 while in SCAN.
  - Verification asserts this.
  - Verification also asserts y_valid -> pend!=0.

Decomposition:
- Shared constants header: state encodings ST_IDLE=1'b0 and ST_SCAN=1'b1, and the default N/W.
- One combinational sub-module, lsb_find: from an N-bit vector it outputs the lowest set index (W bits), the one-hot mask of that bit, and an "exactly one bit set" flag.
- The parent holds the FSM and the pend register, and clears pend with pend & ~mask.

Test Plan:
1. Reset, then idle: hold rst=1 for 2 cycles, then release -> in_ready=1, y_valid=0, y=0, y_last=0, zero=0.
2. One-hot vector: I=4'b0100 with in_valid=1 and y_ready=1 -> next cycle y=2, y_valid=1, y_last=1; the cycle after, in_ready=1.
3. Multi-bit vector: I=4'b1011 with y_ready=1 -> y=0,1,3 on consecutive cycles, y_last=1 only with y=3; I=4'b1111 -> y=0,1,2,3.
4. Backpressure and ignored input: I=4'b0110, y_ready=0 for 5 cycles while in_valid=1 with I=4'b1000 -> y=1 held stable and I=4'b1000 not latched; then y_ready=1 -> y=1, then y=2 with last.
5. Zero vector: I=4'b0000 accepted -> zero=1 for exactly one cycle, y_valid stays 0, in_ready stays 1.
6. Reset mid-scan: I=4'b1110, accept y=1, then assert rst -> next cycle y_valid=0, in_ready=1; a following I=4'b0001 yields y=0 with last, with no stale codes.

Source files
------------

// File: rtl/encode4_2_seq_pkg.sv
// Shared constants for the sequential 4-to-2 encoder.
//   ST_IDLE / ST_SCAN : FSM state encodings (1-bit, legacy-compatible)
//   DEF_N / DEF_W     : default request-vector width and code width
package encode4_2_seq_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam int DEF_N = 4;
  localparam int DEF_W = 2;

endpackage

// File: rtl/encode4_2_seq_lsb_find.sv
// Combinational lowest-set-bit finder.
//   vec_i  [N-1:0] : input vector
//   idx_o  [W-1:0] : index of the lowest set bit (0 when vec_i is zero)
//   mask_o [N-1:0] : one-hot mask of that bit (0 when vec_i is zero)
//   one_o          : vec_i has exactly one bit set
module lsb_find #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] mask_o,
  output logic         one_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign mask_o = vec_i & (~vec_i + N'(1));

  // Clearing the lowest bit leaves nothing exactly when one bit was set.
  assign one_o = (vec_i != '0) && ((vec_i & ~mask_o) == '0);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (vec_i[k]) begin
        idx_o = W'(k);
      end
    end
  end

endmodule

// File: rtl/encode4_2_seq.sv
// Sequential N-to-W encoder: latches a request vector through a valid/ready
// handshake, then emits the index of every set bit, lowest first, one per
// output handshake, flagging the final one with y_last.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake for request vector I
//   I        [N-1:0]      : request vector
//   y        [W-1:0]      : emitted code
//   y_valid / y_ready     : output handshake
//   y_last                : current code is the final one of its vector
//   zero                  : one-cycle pulse after an all-zero vector is taken
// All outputs are driven from registered state only.
module encode4_2_seq
  import encode4_2_seq_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] I,
  output logic [W-1:0] y,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         y_last,
  output logic         zero
);

  generate
    if (N < 2 || (1 << W) != N) begin : g_bad_params
      $error("encode4_2_seq: N must be a power of two >= 2 and W = log2(N)");
    end
  endgenerate

  logic [0:0]   state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic         zero_q, zero_d;

  logic [W-1:0] low_idx;
  logic [N-1:0] low_mask;
  logic         low_one;

  lsb_find #(.N(N), .W(W)) u_lsb_find (
    .vec_i  (pend_q),
    .idx_o  (low_idx),
    .mask_o (low_mask),
    .one_o  (low_one)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (I != '0) begin
            pend_d  = I;
            state_d = ST_SCAN;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      default: begin
        if (y_ready) begin
          // Retire the code being presented; the last one returns to IDLE.
          pend_d = pend_q & ~low_mask;
          if (low_one) begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign y_valid  = (state_q == ST_SCAN);
  // Gated so y reads 0 outside SCAN even if pend holds a stale value.
  assign y        = y_valid ? low_idx : '0;
  assign y_last   = y_valid & low_one;
  assign zero     = zero_q;

endmodule
